// File: rtl/gslcd_pixel_unpack.sv
// Unpacks 32-bit AXI read beats of packed 24 bpp framebuffer data into one pixel per transfer.
// Optional macro GSLCD_UNPACK_RGB_SWAP_EN swaps R and B on out_data for BGR panels.
module gslcd_pixel_unpack #(
    parameter int FRAME_PIXELS = 384000,
    parameter int PCNT_WIDTH   = 19
) (
    input  logic                  axi_aclk,
    input  logic                  axi_areset,
    input  logic                  flush,
    input  logic [31:0]           in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [23:0]           out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_eof,
    output logic [PCNT_WIDTH-1:0] pix_count
);

    localparam logic [PCNT_WIDTH-1:0] LAST_PIX = PCNT_WIDTH'(FRAME_PIXELS - 1);

    logic [55:0]           byte_buf;
    logic [55:0]           buf_next;
    logic [55:0]           keep_mask;
    logic [5:0]            wr_shift;
    logic [2:0]            count;
    logic [2:0]            count_next;
    logic [PCNT_WIDTH-1:0] pcnt_next;
    logic                  push;
    logic                  pop;

    // Accept only when a whole word still fits, so the buffer never exceeds 7 bytes.
    assign in_ready  = (count <= 3'd3);
    assign out_valid = (count >= 3'd3);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_eof   = out_valid && (pix_count == LAST_PIX);

`ifdef GSLCD_UNPACK_RGB_SWAP_EN
    assign out_data = {byte_buf[7:0], byte_buf[15:8], byte_buf[23:16]};
`else
    assign out_data = byte_buf[23:0];
`endif

    // Pop first, then append the new word at the post-pop fill level. Bytes above the
    // fill level are kept at zero so out_data reads 0 when the buffer is empty.
    always_comb begin
        buf_next   = byte_buf;
        count_next = count;
        pcnt_next  = pix_count;
        keep_mask  = '0;
        wr_shift   = '0;
        if (pop) begin
            buf_next   = byte_buf >> 24;
            count_next = count - 3'd3;
            pcnt_next  = (pix_count == LAST_PIX) ? '0 : pix_count + 1'b1;
        end
        if (push) begin
            wr_shift   = {count_next, 3'b000};
            keep_mask  = ~(56'hFF_FFFF_FFFF_FFFF << wr_shift);
            buf_next   = (buf_next & keep_mask) | ({24'd0, in_data} << wr_shift);
            count_next = count_next + 3'd4;
        end
        if (flush) begin
            buf_next   = '0;
            count_next = '0;
            pcnt_next  = '0;
        end
    end

    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            byte_buf  <= '0;
            count     <= '0;
            pix_count <= '0;
        end else begin
            byte_buf  <= buf_next;
            count     <= count_next;
            pix_count <= pcnt_next;
        end
    end

endmodule
